// File: rtl/mem_resp_tracker_pkg.sv
// mem_resp_tracker_pkg: load-op encoding shared by the MEM-stage response tracker and load aligner
package mem_resp_tracker_pkg;
    localparam int LD_OP_WD = 7;
    localparam int LD_LW  = 6;
    localparam int LD_LB  = 5;
    localparam int LD_LBU = 4;
    localparam int LD_LH  = 3;
    localparam int LD_LHU = 2;
    localparam int LD_LWL = 1;
    localparam int LD_LWR = 0;
    typedef logic [LD_OP_WD-1:0] ld_op_t;
endpackage

// File: rtl/mem_resp_tracker_load_align.sv
// mem_resp_tracker_load_align: aligns/extends load data and builds per-byte GPR write enables
module mem_resp_tracker_load_align
    import mem_resp_tracker_pkg::*;
(
    input  logic [LD_OP_WD-1:0] ld_op,
    input  logic [1:0]          addr_lo,
    input  logic                gr_we,
    input  logic [31:0]         data,
    output logic [31:0]         ld_result,
    output logic [3:0]          ld_rf_we
);
    logic [31:0] sh_r, sh_l;
    logic [15:0] half;
    // 3-p on two bits is simply ~p
    assign sh_r = data >> {addr_lo, 3'b000};
    assign sh_l = data << {~addr_lo, 3'b000};
    assign half = addr_lo[1] ? data[31:16] : data[15:0];
    assign ld_result = ld_op[LD_LW]  ? data :
                       ld_op[LD_LB]  ? {{24{sh_r[7]}}, sh_r[7:0]} :
                       ld_op[LD_LBU] ? {24'd0, sh_r[7:0]} :
                       ld_op[LD_LH]  ? {{16{half[15]}}, half} :
                       ld_op[LD_LHU] ? {16'd0, half} :
                       ld_op[LD_LWL] ? sh_l :
                       ld_op[LD_LWR] ? sh_r : data;
    assign ld_rf_we = ld_op[LD_LWL] ? {1'b1, addr_lo != 2'd0, addr_lo[1], addr_lo == 2'd3} :
                      ld_op[LD_LWR] ? {addr_lo == 2'd0, !addr_lo[1], addr_lo != 2'd3, 1'b1} :
                      {4{gr_we}};
endmodule

// File: rtl/mem_resp_tracker.sv
// mem_resp_tracker: counts in-flight data requests, drops stale responses after a flush and
// buffers returned rdata in order until the MS op consumes it
module mem_resp_tracker
    import mem_resp_tracker_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                req_fire,
    output logic                req_allow,
    input  logic                data_ok,
    input  logic [31:0]         rdata,
    input  logic                flush,
    input  logic                ms_consume,
    output logic                resp_valid,
    input  logic [LD_OP_WD-1:0] ld_op,
    input  logic [1:0]          addr_lo,
    input  logic                gr_we,
    output logic [31:0]         ld_result,
    output logic [3:0]          ld_rf_we
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0] inflight, cancel_cnt, fcnt, inflight_nxt;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [31:0]      mem [DEPTH];
    logic [31:0]      head;
    logic             buffered, live, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p == PTR_W'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign buffered     = fcnt != '0;
    assign live         = data_ok && cancel_cnt == '0 && !flush;
    assign push         = live && !(BYPASS && !buffered && ms_consume);
    assign pop          = ms_consume && buffered && !flush;
    assign resp_valid   = !flush && (buffered || (BYPASS && live));
    assign req_allow    = ({1'b0, inflight} + {1'b0, fcnt}) < (CNT_W + 1)'(DEPTH);
    assign head         = buffered ? mem[rd_ptr] : rdata;
    assign inflight_nxt = inflight + CNT_W'(req_fire) - CNT_W'(data_ok);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight   <= '0;
            cancel_cnt <= '0;
            fcnt       <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            inflight   <= inflight_nxt;
            // after a flush every request still outstanding is stale
            cancel_cnt <= flush ? inflight_nxt : cancel_cnt - CNT_W'(data_ok && cancel_cnt != '0);
            fcnt       <= flush ? '0 : fcnt + CNT_W'(push) - CNT_W'(pop);
            rd_ptr     <= flush ? '0 : pop ? ptr_inc(rd_ptr) : rd_ptr;
            wr_ptr     <= flush ? '0 : push ? ptr_inc(wr_ptr) : wr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rdata;
    end

    mem_resp_tracker_load_align u_load_align (
        .ld_op    (ld_op),
        .addr_lo  (addr_lo),
        .gr_we    (gr_we),
        .data     (head),
        .ld_result(ld_result),
        .ld_rf_we (ld_rf_we)
    );

    a_req_allowed: assert property (@(posedge clk) disable iff (!resetn) !(req_fire && !req_allow));
    a_consume_valid: assert property (@(posedge clk) disable iff (!resetn) !(ms_consume && !flush && !resp_valid));
    a_no_wrap: assert property (@(posedge clk) disable iff (!resetn) inflight <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_mem_resp_tracker.sv
// tb_mem_resp_tracker: scoreboard bench for mem_resp_tracker (DEPTH=4, BYPASS=1)
module tb_mem_resp_tracker;
    import mem_resp_tracker_pkg::*;

    logic clk = 1'b0, resetn = 1'b0;
    logic req_fire = 0, data_ok = 0, flush = 0, ms_consume = 0, gr_we = 1;
    logic [31:0] rdata = '0;
    logic [1:0] addr_lo = '0;
    logic [LD_OP_WD-1:0] ld_op;
    logic req_allow, resp_valid;
    logic [31:0] ld_result;
    logic [3:0] ld_rf_we;

    int checks = 0, errors = 0;
    int m_infl = 0, m_cancel = 0, opi = LD_LW;
    logic [31:0] q[$];
    logic [31:0] obs_res;
    logic [3:0] obs_we;

    assign ld_op = opi < 0 ? '0 : LD_OP_WD'(1) << opi;

    always #5 clk = ~clk;

    mem_resp_tracker dut (
        .clk(clk), .resetn(resetn), .req_fire(req_fire), .req_allow(req_allow),
        .data_ok(data_ok), .rdata(rdata), .flush(flush), .ms_consume(ms_consume),
        .resp_valid(resp_valid), .ld_op(ld_op), .addr_lo(addr_lo), .gr_we(gr_we),
        .ld_result(ld_result), .ld_rf_we(ld_rf_we)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fmt(input int o, input logic [1:0] a, input logic [31:0] d);
        logic [7:0] b;
        logic [15:0] h;
        b = d[8*a +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (o)
            LD_LB:   return {{24{b[7]}}, b};
            LD_LBU:  return {24'd0, b};
            LD_LH:   return {{16{h[15]}}, h};
            LD_LHU:  return {16'd0, h};
            LD_LWL:  return d << (8 * (3 - a));
            LD_LWR:  return d >> (8 * a);
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] fmt_we(input int o, input logic [1:0] a, input logic g);
        case (o)
            LD_LWL:  return a == 0 ? 4'b1000 : a == 1 ? 4'b1100 : a == 2 ? 4'b1110 : 4'b1111;
            LD_LWR:  return a == 0 ? 4'b1111 : a == 1 ? 4'b0111 : a == 2 ? 4'b0011 : 4'b0001;
            default: return {4{g}};
        endcase
    endfunction

    // one clock: drive, sample 1ns later, score, advance model, move to 1ns past next edge
    task automatic cyc(input logic rf, input logic dok, input logic [31:0] rd, input logic fl, input logic mc);
        logic emp, live;
        logic [31:0] d;
        req_fire = rf; data_ok = dok; rdata = rd; flush = fl; ms_consume = mc;
        #1;
        emp = q.size() == 0;
        live = dok && m_cancel == 0 && !fl;
        obs_res = ld_result;
        obs_we = ld_rf_we;
        check("req_allow", req_allow, 32'(m_infl + q.size() < 4));
        check("resp_valid", resp_valid, 32'(!fl && (!emp || live)));
        if (mc && !fl) begin
            if (emp) d = rd;
            else d = q.pop_front();
            if (opi >= 0) check("ld_result", ld_result, fmt(opi, addr_lo, d));
            check("ld_rf_we", ld_rf_we, fmt_we(opi, addr_lo, gr_we));
        end
        if (fl) q.delete();
        else if (live && !(emp && mc)) q.push_back(rd);
        if (fl) m_cancel = m_infl + rf - dok;
        else if (dok && m_cancel != 0) m_cancel--;
        m_infl = m_infl + rf - dok;
        @(posedge clk);
        #1;
    endtask

    typedef struct {int op; logic [1:0] p; logic [31:0] d; logic [31:0] res; logic [3:0] we;} fmt_t;
    fmt_t tbl[6] = '{
        '{LD_LB,  2'd3, 32'h80112233, 32'hFFFFFF80, 4'hF},
        '{LD_LBU, 2'd3, 32'h80112233, 32'h00000080, 4'hF},
        '{LD_LWL, 2'd1, 32'h11223344, 32'h33440000, 4'b1100},
        '{LD_LWR, 2'd2, 32'h11223344, 32'h00001122, 4'b0011},
        '{LD_LH,  2'd2, 32'h80112233, 32'hFFFF8011, 4'hF},
        '{LD_LHU, 2'd0, 32'h80112233, 32'h00002233, 4'hF}
    };

    initial begin
        #2;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_req_allow", req_allow, 1);
        #10 resetn = 1'b1;
        @(posedge clk);
        #1;
        check("rst_inflight", 32'(dut.inflight), 0);
        check("rst_cancel", 32'(dut.cancel_cnt), 0);

        // LW with bypass: data_ok two cycles after the request
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 32'h89ABCDEF, 0, 1);
        check("t1_res", obs_res, 32'h89ABCDEF);
        check("t1_we", obs_we, 4'hF);

        foreach (tbl[i]) begin
            opi = tbl[i].op;
            addr_lo = tbl[i].p;
            cyc(1, 0, 0, 0, 0);
            cyc(0, 1, tbl[i].d, 0, 1);
            check("tbl_res", obs_res, tbl[i].res);
            check("tbl_we", obs_we, tbl[i].we);
        end
        opi = LD_LW;
        addr_lo = 2'd0;

        // fill to DEPTH, then buffered entry still blocks until consumed
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0);
        check("t3_full", req_allow, 0);
        cyc(0, 1, 32'hA0000001, 0, 0);
        check("t3_held", req_allow, 0);
        cyc(0, 0, 0, 0, 1);
        check("t3_free", req_allow, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'hA0000010 + i, 0, 1);

        // flush with coincident request: four stale responses
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0);
        check("t4_cancel", 32'(dut.cancel_cnt), 4);
        for (int i = 0; i < 4; i++) cyc(0, 1, 32'hDEAD0000 + i, 0, 0);
        check("t4_cancel0", 32'(dut.cancel_cnt), 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'hCAFEF00D, 0, 1);
        check("t4_fifth", obs_res, 32'hCAFEF00D);

        // flush coincident with data_ok
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'hBAD00001, 1, 0);
        check("t5_cancel", 32'(dut.cancel_cnt), 1);
        check("t5_fcnt", 32'(dut.fcnt), 0);
        cyc(0, 1, 32'hBAD00002, 0, 0);

        // two buffered, then push+pop together
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'h11110000, 0, 0);
        cyc(0, 1, 32'h22220000, 0, 0);
        check("t6_fcnt2", 32'(dut.fcnt), 2);
        cyc(0, 1, 32'h33330000, 0, 1);
        check("t6_pushpop_res", obs_res, 32'h11110000);
        check("t6_fcnt_keep", 32'(dut.fcnt), 2);
        cyc(1, 0, 0, 0, 1);
        check("t6_order", obs_res, 32'h22220000);

        // asynchronous reset mid-stream
        req_fire = 0; data_ok = 0; ms_consume = 0;
        #2 resetn = 1'b0;
        #1;
        check("t6_rst_valid", resp_valid, 0);
        check("t6_rst_allow", req_allow, 1);
        check("t6_rst_infl", 32'(dut.inflight), 0);
        check("t6_rst_fcnt", 32'(dut.fcnt), 0);
        check("t6_rst_cancel", 32'(dut.cancel_cnt), 0);
        q.delete();
        m_infl = 0;
        m_cancel = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 32'h5A5A1234, 0, 1);
        check("post_rst_res", obs_res, 32'h5A5A1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
